// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit, Moore FSM with a memory-ready handshake.
// Optional feature: define MC_CTRL_BNE_EN to decode bne (opcode 000101) into state BNE=12.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrc_B,
    output logic       ZeroExt,
    output logic [2:0] ALU_Control,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       Branch,
    output logic       BranchNE,
    output logic       Jump,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] S_IF   = 4'd0;
    localparam logic [3:0] S_ID   = 4'd1;
    localparam logic [3:0] S_EX_R = 4'd2;
    localparam logic [3:0] S_WB_R = 4'd3;
    localparam logic [3:0] S_MA   = 4'd4;
    localparam logic [3:0] S_MR   = 4'd5;
    localparam logic [3:0] S_WB_L = 4'd6;
    localparam logic [3:0] S_MW   = 4'd7;
    localparam logic [3:0] S_EX_I = 4'd8;
    localparam logic [3:0] S_WB_I = 4'd9;
    localparam logic [3:0] S_BEQ  = 4'd10;
    localparam logic [3:0] S_J    = 4'd11;
`ifdef MC_CTRL_BNE_EN
    localparam logic [3:0] S_BNE  = 4'd12;
    localparam logic [5:0] OP_BNE = 6'b000101;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Returns {legal, alu_op} for an R-type funct field.
    function automatic logic [3:0] r_decode(input logic [5:0] f);
        case (f)
            6'b100000: r_decode = {1'b1, ALU_ADD};
            6'b100010: r_decode = {1'b1, ALU_SUB};
            6'b100100: r_decode = {1'b1, ALU_AND};
            6'b100101: r_decode = {1'b1, ALU_OR};
            6'b100110: r_decode = {1'b1, ALU_XOR};
            6'b100111: r_decode = {1'b1, ALU_NOR};
            6'b101010: r_decode = {1'b1, ALU_SLT};
            6'b000010: r_decode = {1'b1, ALU_SRL};
            default:   r_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    logic [3:0] state_q, state_d;
    logic       is_lw_q, is_lw_d;
    logic [2:0] imm_alu_q, imm_alu_d;
    logic       imm_zext_q, imm_zext_d;
    logic [3:0] r_dec;
    logic       unused_zero;

    assign unused_zero = zero;
    assign r_dec       = r_decode(funct);

    // Opcode-derived details are latched in ID so later states do not depend on the IR.
    always_comb begin
        is_lw_d    = (opcode == OP_LW);
        imm_zext_d = (opcode == OP_ANDI) || (opcode == OP_ORI);
        case (opcode)
            OP_SLTI: imm_alu_d = ALU_SLT;
            OP_ANDI: imm_alu_d = ALU_AND;
            OP_ORI:  imm_alu_d = ALU_OR;
            default: imm_alu_d = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
        if (state_q == S_ID) begin
            is_lw_q    <= is_lw_d;
            imm_alu_q  <= imm_alu_d;
            imm_zext_q <= imm_zext_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_RTYPE:                          state_d = r_dec[3] ? S_EX_R : S_IF;
                    OP_LW, OP_SW:                      state_d = S_MA;
                    OP_BEQ:                            state_d = S_BEQ;
                    OP_J:                              state_d = S_J;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EX_I;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:                            state_d = S_BNE;
`endif
                    default:                           state_d = S_IF;
                endcase
            end
            S_EX_R:  state_d = S_WB_R;
            S_MA:    state_d = is_lw_q ? S_MR : S_MW;
            S_MR:    state_d = mem_ready ? S_WB_L : S_MR;
            S_MW:    state_d = mem_ready ? S_IF : S_MW;
            S_EX_I:  state_d = S_WB_I;
            default: state_d = S_IF;
        endcase
    end

    // ID only falls back to IF when the instruction cannot be decoded.
    always_comb begin
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrc_B    = 2'b00;
        ZeroExt     = 1'b0;
        ALU_Control = ALU_AND;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        Branch      = 1'b0;
        BranchNE    = 1'b0;
        Jump        = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        state       = 4'd0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                S_IF: begin
                    MemRead     = 1'b1;
                    ALUSrc_B    = 2'b01;
                    ALU_Control = ALU_ADD;
                    IRWrite     = mem_ready;
                    PCWrite     = mem_ready;
                end
                S_ID: begin
                    ALUSrc_B    = 2'b11;
                    ALU_Control = ALU_ADD;
                    illegal     = (state_d == S_IF);
                    retire      = (state_d == S_IF);
                end
                S_EX_R: begin
                    ALUSrcA     = 1'b1;
                    ALU_Control = r_dec[2:0];
                end
                S_WB_R: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MA: begin
                    ALUSrcA     = 1'b1;
                    ALUSrc_B    = 2'b10;
                    ALU_Control = ALU_ADD;
                end
                S_MR: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_WB_L: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MW: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    retire   = mem_ready;
                end
                S_EX_I: begin
                    ALUSrcA     = 1'b1;
                    ALUSrc_B    = 2'b10;
                    ALU_Control = imm_alu_q;
                    ZeroExt     = imm_zext_q;
                end
                S_WB_I: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALU_Control = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    Branch      = 1'b1;
                    retire      = 1'b1;
                end
                S_J: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    Jump     = 1'b1;
                    retire   = 1'b1;
                end
`ifdef MC_CTRL_BNE_EN
                S_BNE: begin
                    ALUSrcA     = 1'b1;
                    ALU_Control = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNE    = 1'b1;
                    retire      = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It decodes `opcode`/`funct` from the instruction register and walks each instruction through fetch, decode, execute, memory and write-back states. In each state it drives the datapath control lines, including `RegDst`, `MemtoReg`, `ALU_Control`, `RegWrite`, `Branch` and `Jump`. It stalls on a memory-ready handshake and sits between the datapath and the memory/IO controller.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag; used by the datapath only, listed for the bench.
- `mem_ready` in 1: memory completes the current access this cycle.
- `MemRead` out 1
- `MemWrite` out 1
- `IorD` out 1: 0 = PC address, 1 = ALUOut address.
- `IRWrite` out 1
- `PCWrite` out 1: unconditional PC write.
- `PCWriteCond` out 1: PC write gated by branch condition.
- `PCSource` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrc_B` out 2: 00 = B, 01 = 4, 10 = immediate, 11 = immediate<<2.
- `ZeroExt` out 1: immediate zero-extended (andi/ori).
- `ALU_Control` out 3
- `RegDst` out 1
- `MemtoReg` out 1
- `RegWrite` out 1
- `Branch` out 1: beq condition select.
- `BranchNE` out 1: bne condition select.
- `Jump` out 1
- `retire` out 1: one-cycle pulse on the last cycle of every instruction.
- `illegal` out 1: one-cycle pulse when an undecodable instruction is seen.
- `state` out 4: current state code, for debug.

## Operation
- Moore FSM. All outputs decode from `state`. `PCWrite` and `IRWrite` in IF are additionally gated by `mem_ready`.
- `ALU_Control` encoding: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL, 110 SUB, 111 SLT.
- State codes and actions (any output not listed is 0):
  - IF=0: `MemRead`, `IorD`=0, `ALUSrcA`=0, `ALUSrc_B`=01, ADD, `PCSource`=00. `IRWrite` and `PCWrite` are asserted only when `mem_ready`. Stay in IF while `!mem_ready`; go to ID when it is set.
  - ID=1: `ALUSrcA`=0, `ALUSrc_B`=11, ADD. Dispatch on `opcode`:
    - 000000 → EX_R if `funct` is legal.
    - 100011 / 101011 → MA.
    - 000100 → BEQ.
    - 000010 → J.
    - 001000 / 001010 / 001100 / 001101 → EX_I.
    - Anything else → IF, pulsing `illegal` and `retire`.
- R-type:
  - EX_R=2: `ALUSrcA`=1, `ALUSrc_B`=00. `ALU_Control` from `funct`: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000010 SRL. Any other funct is illegal and is trapped in ID.
  - WB_R=3: `RegDst`=1, `MemtoReg`=0, `RegWrite`, `retire` → IF.
- Load/store:
  - MA=4: `ALUSrcA`=1, `ALUSrc_B`=10, ADD → MR for lw, MW for sw.
  - MR=5: `MemRead`, `IorD`=1. Wait for `mem_ready` → WB_L.
  - WB_L=6: `RegDst`=0, `MemtoReg`=1, `RegWrite`, `retire` → IF.
  - MW=7: `MemWrite`, `IorD`=1. On `mem_ready` pulse `retire` → IF.
- Immediate ALU:
  - EX_I=8: `ALUSrcA`=1, `ALUSrc_B`=10. ALU op: ADD for addi, SLT for slti, AND for andi, OR for ori. `ZeroExt`=1 for andi/ori.
  - WB_I=9: `RegDst`=0, `MemtoReg`=0, `RegWrite`, `retire` → IF.
- Branch and jump:
  - BEQ=10: `ALUSrcA`=1, `ALUSrc_B`=00, SUB, `PCWriteCond`, `PCSource`=01, `Branch`, `retire` → IF.
  - J=11: `PCWrite`, `PCSource`=10, `Jump`, `retire` → IF.
- Codes 12–15 are unused. If entered, the FSM goes to IF on the next edge with no outputs asserted.

## Timing
- Reset:
  - `rst` high at a rising edge sets `state`=IF.
  - While `rst`=1, every output is forced to 0 combinationally.
  - In the first cycle after release the IF outputs appear.
  - Reset mid-instruction, including mid-wait, abandons the instruction; no `retire` is issued.
- Latency with `mem_ready` always 1: R-type, I-type ALU and sw take 4 cycles; lw takes 5; beq and j take 3; illegal takes 2. Each memory wait cycle adds 1.
- Memory handshake:
  - `MemRead`/`MemWrite` stay steady until the cycle in which `mem_ready`=1.
  - The transfer completes in that cycle and the FSM advances on the next edge.
  - `mem_ready` is ignored outside IF, MR and MW.
- Decode timing:
  - `opcode` and `funct` are sampled only in ID and EX_R (EX_R uses `funct`).
  - The IR must be stable from the edge that ends IF.
- `retire` is asserted in the final state's cycle, so exactly one pulse per instruction.

## Configuration
- `MC_CTRL_BNE_EN`:
  - Defined: opcode 000101 dispatches from ID to BNE=12. BNE matches BEQ except that `BranchNE`=1 and `Branch`=0.
  - Undefined: 000101 is illegal, `BranchNE` is tied to 0 and code 12 is unused.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `mem_ready`=1, then release.
  - During reset all outputs are 0 and `state`=0.
  - In the first cycle after release `MemRead`=1, `PCWrite`=1 and `IRWrite`=1.
- add (opcode 0, funct 100000): states 0,1,2,3. `ALU_Control`=010 in state 2; `RegWrite`=1 and `RegDst`=1 in state 3; `retire` in cycle 4.
- lw with `mem_ready` low for 3 cycles in MR: state 5 holds for 4 cycles with `MemRead`=1 and `IorD`=1. Then WB_L shows `MemtoReg`=1 and `RegWrite`=1. Total 8 cycles.
- beq then j: beq shows `PCWriteCond`=1, `Branch`=1, `ALU_Control`=110 in state 10. j shows `PCWrite`=1, `PCSource`=10, `Jump`=1. Each takes 3 cycles.
- Illegal cases:
  - opcode 111111 → `illegal` and `retire` pulse in ID, then back to IF.
  - R-type with funct 111111 → same.
  - Without the macro, opcode 000101 → `illegal`.
  - With `MC_CTRL_BNE_EN` defined, opcode 000101 → state 12 with `BranchNE`=1.
- Reset mid-instruction: assert `rst` in MW while `mem_ready`=0. The next state is 0, `MemWrite` drops the same cycle and no `retire` pulse occurs.
